// File: rtl/unidad_control_if.sv
// ----------------------------------------------------------------------------
// unidad_control_if
//   Bundles the buses the control unit drives or observes: the instruction
//   memory port, the datapath control/flag signals, the data memory strobes
//   and a small debug view of the internal state.
//
//   Strobe semantics (one description for every strobe on this bus):
//     imem_rd : while high, the memory samples imem_addr on the next rising
//               edge and presents imem_data in the following cycle.
//     mem_rd  : one-cycle request; the datapath's adr_out is the address and
//               the read data is written back during the next (MEM) cycle.
//     mem_we  : one-cycle write request; the datapath's dataout is the data.
//     No strobe is held waiting for an acknowledge; there is no back-pressure.
//     At most one of imem_rd / mem_rd / mem_we is high in any cycle.
//
//   Signals
//     imem_data   in  16    instruction read data
//     flags       in  4     datapath flags {V,C,N,Z}
//     imem_addr   out PC_W  instruction address (the program counter)
//     imem_rd     out 1     instruction read strobe
//     control     out 16    datapath control word
//     Constant_IN out 4     immediate for the datapath (IR[3:0])
//     mem_rd      out 1     data memory read strobe
//     mem_we      out 1     data memory write strobe
//     halted      out 1     high while in HALT
//     dbg_state   out 3     FSM state (FETCH=0 DECODE=1 EXEC=2 MEM=3 HALT=4)
//     dbg_flags_q out 4     flags latched by the last ALU/shift instruction
//
//   Modports: master = control unit, slave = memory/datapath side.
// ----------------------------------------------------------------------------
interface unidad_control_if #(
  parameter int PC_W = 8
);
  logic [15:0]     imem_data;
  logic [3:0]      flags;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [15:0]     control;
  logic [3:0]      Constant_IN;
  logic            mem_rd;
  logic            mem_we;
  logic            halted;
  logic [2:0]      dbg_state;
  logic [3:0]      dbg_flags_q;

  modport master (
    input  imem_data, flags,
    output imem_addr, imem_rd, control, Constant_IN, mem_rd, mem_we, halted,
           dbg_state, dbg_flags_q
  );

  modport slave (
    output imem_data, flags,
    input  imem_addr, imem_rd, control, Constant_IN, mem_rd, mem_we, halted,
           dbg_state, dbg_flags_q
  );
endinterface

// File: rtl/unidad_control.sv
// ----------------------------------------------------------------------------
// unidad_control
//   Control unit for unidad_procesadora. Fetches 16-bit instructions from a
//   synchronous instruction memory, decodes them and drives the datapath
//   control word, the immediate and the data memory strobes. Sequence:
//   FETCH -> DECODE -> EXEC (-> MEM for LD) -> FETCH; HALT is sticky.
//
//   Ports
//     clk    in  1   system clock, rising edge
//     reset  in  1   synchronous, active-high reset
//     step   in  1   single-step enable (only with UNIDAD_CONTROL_STEP_EN)
//     bus    master modport of unidad_control_if (see that file)
//
//   Parameters
//     PC_W      program counter / instruction address width
//     RESET_PC  program counter value after reset
//
//   Build option
//     UNIDAD_CONTROL_STEP_EN : adds the step input; FETCH idles with
//     imem_rd=0 until step is sampled high. Undefined: runs freely.
// ----------------------------------------------------------------------------
module unidad_control #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
`ifdef UNIDAD_CONTROL_STEP_EN
  input  logic step,
`endif
  unidad_control_if.master bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [3:0]      r_flags_q;
  logic [15:0]     r_control;
  logic            r_imem_rd;
  logic            r_mem_rd;
  logic            r_mem_we;
  logic            r_halted;

  logic            w_go;
  logic [3:0]      w_dec_op;
  logic [1:0]      w_dec_rd, w_dec_ra, w_dec_rb;
  logic [15:0]     w_exec_control;
  logic [15:0]     w_mem_control;
  logic [3:0]      w_op;
  logic            w_alu_op;
  logic [PC_W-1:0] w_target;

`ifdef UNIDAD_CONTROL_STEP_EN
  assign w_go = step;
`else
  assign w_go = 1'b1;
`endif

  // The EXEC control word is built from the memory data during DECODE so it
  // can be registered on the DECODE->EXEC edge, together with IR.
  assign w_dec_op = bus.imem_data[15:12];
  assign w_dec_rd = bus.imem_data[11:10];
  assign w_dec_ra = bus.imem_data[9:8];
  assign w_dec_rb = bus.imem_data[7:6];

  // Control word layout: {A,B,D,WE,MB,ALU[3:0],SH[1:0],MF,MD}
  always_comb begin
    w_exec_control = 16'h0000;
    case (w_dec_op)
      OP_MOV:  w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0};
      OP_ADD:  w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b0, 4'b0010, 2'b00, 1'b0, 1'b0};
      OP_SUB:  w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b0, 4'b0101, 2'b00, 1'b0, 1'b0};
      OP_AND:  w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b0, 4'b1000, 2'b00, 1'b0, 1'b0};
      OP_OR:   w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b0, 4'b1010, 2'b00, 1'b0, 1'b0};
      OP_XOR:  w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b0, 4'b1100, 2'b00, 1'b0, 1'b0};
      OP_ADDI: w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b1, 4'b0010, 2'b00, 1'b0, 1'b0};
      // LDI routes the constant through the B mux and the shifter in pass mode.
      OP_LDI:  w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b0};
      OP_SHL:  w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b1, 1'b0};
      OP_SHR:  w_exec_control = {w_dec_ra, w_dec_rb, w_dec_rd, 1'b1, 1'b0, 4'b0000, 2'b01, 1'b1, 1'b0};
      OP_LD:   w_exec_control = {w_dec_ra, 14'h0000};
      OP_ST:   w_exec_control = {w_dec_ra, w_dec_rb, 12'h000};
      default: w_exec_control = 16'h0000;
    endcase
  end

  assign w_op          = r_ir[15:12];
  assign w_alu_op      = (w_op >= OP_MOV) && (w_op <= OP_SHR);
  assign w_mem_control = {r_ir[9:8], 2'b00, r_ir[11:10], 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1};
  assign w_target      = PC_W'(r_ir[7:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 16'h0000;
      r_flags_q <= 4'h0;
      r_control <= 16'h0000;
      r_imem_rd <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        // FETCH is entered with imem_rd already registered high when the
        // unit may proceed; otherwise it idles with imem_rd=0 (after reset
        // or while waiting for step) and raises it once w_go is seen.
        ST_FETCH: begin
          if (r_imem_rd) begin
            r_imem_rd <= 1'b0;
            r_state   <= ST_DECODE;
          end else begin
            r_imem_rd <= w_go;
          end
        end
        ST_DECODE: begin
          r_ir      <= bus.imem_data;
          r_pc      <= r_pc + PC_W'(1);
          r_control <= w_exec_control;
          r_mem_rd  <= (w_dec_op == OP_LD);
          r_mem_we  <= (w_dec_op == OP_ST);
          r_state   <= ST_EXEC;
        end
        ST_EXEC: begin
          r_control <= 16'h0000;
          r_mem_rd  <= 1'b0;
          r_mem_we  <= 1'b0;
          if (w_alu_op) r_flags_q <= bus.flags;
          case (w_op)
            OP_LD: begin
              r_control <= w_mem_control;
              r_state   <= ST_MEM;
            end
            OP_BZ: begin
              if (r_flags_q[0]) r_pc <= w_target;
              r_imem_rd <= w_go;
              r_state   <= ST_FETCH;
            end
            OP_JMP: begin
              r_pc      <= w_target;
              r_imem_rd <= w_go;
              r_state   <= ST_FETCH;
            end
            OP_HALT: begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
            default: begin
              r_imem_rd <= w_go;
              r_state   <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          r_control <= 16'h0000;
          r_imem_rd <= w_go;
          r_state   <= ST_FETCH;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  // Control word and strobes are forced low while reset is asserted so an
  // instruction caught mid-EXEC/MEM never produces a write in that cycle.
  assign bus.control     = reset ? 16'h0000 : r_control;
  assign bus.imem_rd     = r_imem_rd & ~reset;
  assign bus.mem_rd      = r_mem_rd & ~reset;
  assign bus.mem_we      = r_mem_we & ~reset;
  assign bus.imem_addr   = r_pc;
  assign bus.Constant_IN = r_ir[3:0];
  assign bus.halted      = r_halted;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_flags_q = r_flags_q;

endmodule

// File: tb/tb_unidad_control.sv
`timescale 1ns/1ps
module tb_unidad_control;
  localparam int PC_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
`ifdef UNIDAD_CONTROL_STEP_EN
  logic step;
`endif
  always #5 clk = ~clk;

  unidad_control_if #(.PC_W(PC_W)) bus ();

  unidad_control #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef UNIDAD_CONTROL_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  // Synchronous instruction ROM: data appears the cycle after imem_rd.
  logic [15:0] rom [0:255];
  always @(posedge clk) if (bus.imem_rd) bus.imem_data <= rom[bus.imem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [PC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [3:0]  flags;     // flags driven during EXEC
    logic [15:0] ctrl;      // expected control in EXEC
    logic [3:0]  cnst;      // expected Constant_IN in EXEC
    logic        mrd;
    logic        mwe;
    logic [15:0] mctrl;     // expected control in MEM (LD only)
    logic [7:0]  nxt;       // expected next fetch address
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  // Entered at the FETCH sample point (imem_rd expected high); leaves at the
  // next FETCH sample point, so the cycle count per instruction is checked.
  task automatic run_vec(input int i);
    vec_t v;
    logic [PC_W-1:0] ea;
    v = vecs[i];
    ea = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check($sformatf("v%0d_fetch_rd", i), 32'(bus.imem_rd), 32'd1);
    check($sformatf("v%0d_fetch_addr", i), 32'(bus.imem_addr), 32'(ea));
    tick();
    check($sformatf("v%0d_decode_ctrl", i), 32'(bus.control), 32'h0);
    tick();
    bus.flags = v.flags;
    check($sformatf("v%0d_exec_ctrl", i), 32'(bus.control), 32'(v.ctrl));
    check($sformatf("v%0d_exec_const", i), 32'(bus.Constant_IN), 32'(v.cnst));
    check($sformatf("v%0d_exec_strobes", i), {29'd0, bus.imem_rd, bus.mem_rd, bus.mem_we},
          {29'd0, 1'b0, v.mrd, v.mwe});
    if (v.mrd) begin
      tick();
      check($sformatf("v%0d_mem_ctrl", i), 32'(bus.control), 32'(v.mctrl));
      check($sformatf("v%0d_mem_strobes", i), {30'd0, bus.mem_rd, bus.mem_we}, 32'd0);
    end
    exp_q.push_back(v.nxt);
    tick();
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1'b1;
    bus.flags = 4'h0;
`ifdef UNIDAD_CONTROL_STEP_EN
    step = 1'b1;
`endif
    //           addr   instr     flg   ctrl      cn    rd    we    mctrl     next
    vecs[0]  = '{8'h00, 16'h8405, 4'h0, 16'h0702, 4'h5, 1'b0, 1'b0, 16'h0000, 8'h01}; // LDI r1,5
    vecs[1]  = '{8'h01, 16'h8803, 4'h0, 16'h0B02, 4'h3, 1'b0, 1'b0, 16'h0000, 8'h02}; // LDI r2,3
    vecs[2]  = '{8'h02, 16'h2D80, 4'h0, 16'h6E20, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h03}; // ADD r3,r1,r2
    vecs[3]  = '{8'h03, 16'h3140, 4'h1, 16'h5250, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h04}; // SUB r0,r1,r1 Z=1
    vecs[4]  = '{8'h04, 16'hD010, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h10}; // BZ taken
    vecs[5]  = '{8'h10, 16'h46C0, 4'h0, 16'hB680, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h11}; // AND Z=0
    vecs[6]  = '{8'h11, 16'hD020, 4'h1, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h12}; // BZ not taken, live Z=1
    vecs[7]  = '{8'h12, 16'h5B00, 4'h1, 16'hCAA0, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h13}; // OR Z=1
    vecs[8]  = '{8'h13, 16'hB900, 4'h0, 16'h4000, 4'h0, 1'b1, 1'b0, 16'h4A01, 8'h14}; // LD r2,[r1]
    vecs[9]  = '{8'h14, 16'hC1C0, 4'h0, 16'h7000, 4'h0, 1'b0, 1'b1, 16'h0000, 8'h15}; // ST [r1],r3
    vecs[10] = '{8'h15, 16'hD030, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h30}; // BZ, flags_q kept
    vecs[11] = '{8'h30, 16'h6180, 4'h0, 16'h62C0, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h31}; // XOR
    vecs[12] = '{8'h31, 16'h7507, 4'h0, 16'h4720, 4'h7, 1'b0, 1'b0, 16'h0000, 8'h32}; // ADDI r1,r1,7
    vecs[13] = '{8'h32, 16'h1B00, 4'h0, 16'hCA00, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h33}; // MOV r2,r3
    vecs[14] = '{8'h33, 16'h9C80, 4'h0, 16'h2E0A, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h34}; // SHL r3,r2
    vecs[15] = '{8'h34, 16'hA040, 4'h0, 16'h1206, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h35}; // SHR r0,r1
    vecs[16] = '{8'h35, 16'h0000, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h36}; // NOP
    vecs[17] = '{8'h36, 16'hE0FF, 4'h0, 16'h0000, 4'hF, 1'b0, 1'b0, 16'h0000, 8'hFF}; // JMP 0xFF
    vecs[18] = '{8'hFF, 16'h0000, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 8'h00}; // NOP, wrap

    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    for (int i = 0; i < NV; i++) rom[vecs[i].addr] = vecs[i].instr;

    // Reset state
    tick();
    tick();
    check("rst_ctrl", 32'(bus.control), 32'h0);
    check("rst_strobes", {29'd0, bus.imem_rd, bus.mem_rd, bus.mem_we}, 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'h00);
    check("rst_const", 32'(bus.Constant_IN), 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    check("rst_flags_q", 32'(bus.dbg_flags_q), 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_idle_rd", 32'(bus.imem_rd), 32'd0);
    tick();

    exp_q.push_back(8'h00);
    for (int i = 0; i < NV; i++) run_vec(i);

    // HALT fetched at the wrapped address 0x00; sticky for 20 cycles.
    rom[0] = 16'hF000;
    check("halt_fetch_addr", 32'(bus.imem_addr), (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF);
    check("halt_fetch_rd", 32'(bus.imem_rd), 32'd1);
    tick();
    tick();
    check("halt_exec_ctrl", 32'(bus.control), 32'h0);
    check("halt_exec_halted", 32'(bus.halted), 32'd0);
    tick();
    for (int c = 0; c < 20; c++) begin
      check($sformatf("halt_c%0d", c),
            {12'd0, bus.halted, bus.control, bus.imem_rd, bus.mem_rd, bus.mem_we},
            {12'd0, 1'b1, 16'h0000, 3'b000});
      tick();
    end

    // Reset out of HALT.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("halt_rst_halted", 32'(bus.halted), 32'd0);
    check("halt_rst_state", 32'(bus.dbg_state), 32'd0);
    check("halt_rst_addr", 32'(bus.imem_addr), 32'h00);

    // Reset arriving during an ADD EXEC: no WE, flags not captured.
    rom[0] = 16'h2D80;
    tick();
    check("radd_fetch_rd", 32'(bus.imem_rd), 32'd1);
    tick();
    tick();
    check("radd_exec_ctrl", 32'(bus.control), 32'h6E20);
    bus.flags = 4'hF;
    reset = 1'b1;
    #1;
    check("radd_rst_ctrl", 32'(bus.control), 32'h0);
    tick();
    check("radd_after_ctrl", 32'(bus.control), 32'h0);
    check("radd_after_addr", 32'(bus.imem_addr), 32'h00);
    check("radd_after_halted", 32'(bus.halted), 32'd0);
    check("radd_after_flags_q", 32'(bus.dbg_flags_q), 32'h0);
    check("radd_after_state", 32'(bus.dbg_state), 32'd0);
    bus.flags = 4'h0;

`ifdef UNIDAD_CONTROL_STEP_EN
    // Single-step: idle with step low, then one pulse runs one instruction.
    rom[0] = 16'h8405;
    step = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("step_idle_c%0d", c), 32'(bus.imem_rd), 32'd0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_fetch_rd", 32'(bus.imem_rd), 32'd1);
    check("step_fetch_addr", 32'(bus.imem_addr), 32'h00);
    tick();
    tick();
    check("step_exec_ctrl", 32'(bus.control), 32'h0702);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("step_after_c%0d", c), {23'd0, bus.imem_rd, bus.imem_addr}, {23'd0, 1'b0, 8'h01});
    end
`else
    reset = 1'b0;
    tick();
    check("free_run_fetch_rd", 32'(bus.imem_rd), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
